// File: rtl/fir_decim_buffer_pkg.sv
// Shared definitions for the FIR decimation buffer: filter geometry,
// FSM encoding and a small width helper.
package fir_decim_buffer_pkg;

    // Geometry of the upstream 74-tap 8-bit FIR filter.
    localparam int FIR_TAPS = 74;
    localparam int SAMPLE_W = 8;

    // Warm-up / run control state.
    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_decim_buffer_sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO. The head entry is always
// presented on dout (0 when empty). A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is ignored.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Qualify requests: no pop from empty, no push into full unless it frees a slot.
    always_comb begin
        empty = (level == '0);
        full  = (level == FULL_LVL);
        rd_en = pop && !empty;
        wr_en = push && (!full || rd_en);
        dout  = empty ? '0 : mem[rd_ptr];
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; occupancy is tracked separately in level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_decim_buffer.sv
// Downstream stage of the FIR filter: drops the warm-up outputs, keeps one
// of every DECIM enabled samples, buffers them in a FWFT FIFO and flags
// (sticky) any kept sample that had to be dropped because the FIFO was full.
module fir_decim_buffer
    import fir_decim_buffer_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DECIM  = 4,
    parameter int DEPTH  = 8,
    parameter int SKIP   = FIR_TAPS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_sample,
    input  logic                     in_en,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output state_t                   dbg_state
);

    localparam int WC_W = cnt_w(SKIP + 1);
    localparam int PH_W = cnt_w(DECIM);
    localparam logic [WC_W-1:0] SKIP_LAST = WC_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(DECIM - 1);
    localparam state_t          RST_STATE = (SKIP == 0) ? ST_RUN : ST_WARMUP;

    state_t            state;
    state_t            state_next;
    logic [WC_W-1:0]   warm_cnt;
    logic [PH_W-1:0]   phase;
    logic              keep;
    logic              drop;
    logic              fifo_empty;
    logic              fifo_full;

    // Handshake: out_data is transferred on every clock where out_valid && out_ready.
    // out_valid only depends on FIFO occupancy, never on out_ready.

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Leave warm-up on the edge that consumes the last discarded sample.
    always_comb begin
        state_next = state;
        case (state)
            ST_WARMUP: if (in_en && (warm_cnt == SKIP_LAST)) state_next = ST_RUN;
            ST_RUN:    state_next = ST_RUN;
            default:   state_next = RST_STATE;
        endcase
    end

    // Per-cycle decisions: keep the phase-0 sample in RUN; drop it if there is no room.
    always_comb begin
        keep      = (state == ST_RUN) && in_en && (phase == '0);
        drop      = keep && fifo_full && !out_ready;
        out_valid = !fifo_empty;
        dbg_state = state;
    end

    // Count discarded samples during warm-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= '0;
        end else if ((state == ST_WARMUP) && in_en) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    // Decimation phase advances only on enabled samples while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if ((state == ST_RUN) && in_en) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

    // Sticky overflow; a drop in the same cycle wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (keep),
        .pop   (out_ready),
        .din   (in_sample),
        .dout  (out_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Bench for fir_decim_buffer: a default instance (DECIM=4, SKIP=74) and a
// pass-through instance (DECIM=1, SKIP=0) share one stimulus stream and are
// each compared every cycle against a queue-based reference model.
module tb_fir_decim_buffer;
    import fir_decim_buffer_pkg::*;

    localparam int DEPTH  = 8;
    localparam int SKIP0  = 74;
    localparam int DECIM0 = 4;
    localparam int SKIP1  = 0;
    localparam int DECIM1 = 1;

    // ---------------- clock / reset block ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_en = 1'b0;
    logic [7:0] in_sample = '0;
    logic       out_ready = 1'b0;
    logic       clr_ovf = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] out_data0, out_data1;
    logic       out_valid0, out_valid1;
    logic [3:0] level0, level1;
    logic       overflow0, overflow1;
    state_t     state0, state1;

    fir_decim_buffer #(.DATA_W(8), .DECIM(DECIM0), .DEPTH(DEPTH), .SKIP(SKIP0)) u_dut0 (
        .clk(clk), .rst(rst), .in_sample(in_sample), .in_en(in_en),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .level(level0), .overflow(overflow0), .clr_ovf(clr_ovf), .dbg_state(state0)
    );

    fir_decim_buffer #(.DATA_W(8), .DECIM(DECIM1), .DEPTH(DEPTH), .SKIP(SKIP1)) u_dut1 (
        .clk(clk), .rst(rst), .in_sample(in_sample), .in_en(in_en),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .level(level1), .overflow(overflow1), .clr_ovf(clr_ovf), .dbg_state(state1)
    );

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int errors  = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         n0 = 0;
    int         n1 = 0;
    logic       ovf0 = 1'b0;
    logic       ovf1 = 1'b0;

    logic [7:0] pop_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sample number n (counted from reset, enabled samples only) is kept when
    // it lies past the warm-up and lands on a multiple of the decimation factor.
    function automatic bit is_kept(input int n, input int skip, input int decim);
        return (n >= skip) && (((n - skip) % decim) == 0);
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic en, input logic [7:0] s, input logic rdy,
                        input logic clr, input logic r);
        bit p, k, d;
        logic [7:0] e;
        in_en = en; in_sample = s; out_ready = rdy; clr_ovf = clr; rst = r;
        if (!r && out_valid0 && rdy) pop_log.push_back(out_data0);
        @(posedge clk);
        if (r) begin
            exp_q0.delete(); n0 = 0; ovf0 = 1'b0;
            exp_q1.delete(); n1 = 0; ovf1 = 1'b0;
        end else begin
            p = (exp_q0.size() > 0) && rdy;
            k = en && is_kept(n0, SKIP0, DECIM0);
            d = k && (exp_q0.size() == DEPTH) && !p;
            if (p) void'(exp_q0.pop_front());
            if (k && !d) exp_q0.push_back(s);
            if (d) ovf0 = 1'b1; else if (clr) ovf0 = 1'b0;
            if (en) n0++;

            p = (exp_q1.size() > 0) && rdy;
            k = en && is_kept(n1, SKIP1, DECIM1);
            d = k && (exp_q1.size() == DEPTH) && !p;
            if (p) void'(exp_q1.pop_front());
            if (k && !d) exp_q1.push_back(s);
            if (d) ovf1 = 1'b1; else if (clr) ovf1 = 1'b0;
            if (en) n1++;
        end
        #1;
        e = (exp_q0.size() > 0) ? exp_q0[0] : 8'h00;
        check("valid0", 32'(out_valid0), 32'(exp_q0.size() > 0));
        check("data0", 32'(out_data0), 32'(e));
        check("level0", 32'(level0), 32'(exp_q0.size()));
        check("ovf0", 32'(overflow0), 32'(ovf0));
        check("state0", 32'(state0), 32'(n0 >= SKIP0));
        e = (exp_q1.size() > 0) ? exp_q1[0] : 8'h00;
        check("valid1", 32'(out_valid1), 32'(exp_q1.size() > 0));
        check("data1", 32'(out_data1), 32'(e));
        check("level1", 32'(level1), 32'(exp_q1.size()));
        check("ovf1", 32'(overflow1), 32'(ovf1));
        check("state1", 32'(state1), 32'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] sp_exp [3];
        int  first_cyc;
        bit  seen;
        logic [3:0] lvl_before;
        sp_exp[0] = 8'h80; sp_exp[1] = 8'h7F; sp_exp[2] = 8'hFF;

        // Signed pass-through on the DECIM=1, SKIP=0 instance.
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        check("rst_valid0", 32'(out_valid0), 32'(0));
        check("rst_level0", 32'(level0), 32'(0));
        check("rst_ovf0", 32'(overflow0), 32'(0));
        check("rst_data0", 32'(out_data0), 32'(0));
        for (int i = 0; i < 3; i++) step(1, sp_exp[i], 0, 0, 0);
        check("sp_level", 32'(level1), 32'(3));
        for (int i = 0; i < 3; i++) begin
            check("sp_data", 32'(out_data1), 32'(sp_exp[i]));
            step(0, 8'h00, 1, 0, 0);
        end
        check("sp_empty", 32'(out_valid1), 32'(0));

        // Warm-up and decimation.
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        pop_log.delete();
        seen = 0; first_cyc = -1;
        for (int i = 0; i < 120; i++) begin
            step(1, 8'(i % 128), 1, 0, 0);
            if (!seen && out_valid0) begin seen = 1; first_cyc = i + 1; end
        end
        check("t1_first_valid_cyc", 32'(first_cyc), 32'(75));
        check("t1_out_count", 32'(pop_log.size()), 32'(12));
        for (int i = 0; i < pop_log.size(); i++) check("t1_out_value", 32'(pop_log[i]), 32'(74 + 4 * i));

        // Backpressure and overflow.
        for (int i = 0; i < 40; i++) step(1, 8'($urandom), 0, 0, 0);
        check("t2_full_level", 32'(level0), 32'(8));
        check("t2_overflow", 32'(overflow0), 32'(1));
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0, 0);
        check("t2_drained", 32'(level0), 32'(0));

        // Full with simultaneous push and pop.
        step(0, 8'h00, 0, 1, 0);
        check("t3_cleared", 32'(overflow0), 32'(0));
        for (int i = 0; i < 64 && exp_q0.size() < DEPTH; i++) step(1, 8'($urandom), 0, 0, 0);
        check("t3_filled", 32'(level0), 32'(8));
        for (int i = 0; i < 16; i++) step(1, 8'($urandom), is_kept(n0, SKIP0, DECIM0), 0, 0);
        check("t3_level_held", 32'(level0), 32'(8));
        check("t3_no_ovf", 32'(overflow0), 32'(0));
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0, 0);

        // clr_ovf without and with a simultaneous drop.
        for (int i = 0; i < 80 && !ovf0; i++) step(1, 8'($urandom), 0, 0, 0);
        check("t4_ovf_set", 32'(overflow0), 32'(1));
        step(0, 8'h00, 0, 1, 0);
        check("t4_clr_plain", 32'(overflow0), 32'(0));
        for (int i = 0; i < 8 && !is_kept(n0, SKIP0, DECIM0); i++) step(1, 8'($urandom), 0, 0, 0);
        step(1, 8'($urandom), 0, 1, 0);
        check("t4_clr_with_drop", 32'(overflow0), 32'(1));

        // Reset mid-stream.
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 64 && exp_q0.size() < 5; i++) step(1, 8'($urandom), 0, 0, 0);
        check("t5_level5", 32'(level0), 32'(5));
        step(0, 8'h00, 0, 0, 1);
        check("t5_rst_valid", 32'(out_valid0), 32'(0));
        check("t5_rst_level", 32'(level0), 32'(0));
        seen = 0;
        for (int i = 0; i < 74; i++) begin
            step(1, 8'($urandom), 1, 0, 0);
            if (out_valid0) seen = 1;
        end
        check("t5_warmup_silent", 32'(seen), 32'(0));
        for (int i = 0; i < 20; i++) step(1, 8'($urandom), 1, 0, 0);

        // Gating: in_en low holds phase and level.
        lvl_before = level0;
        for (int i = 0; i < 10; i++) step(0, 8'($urandom), 0, 0, 0);
        check("t6_gate_level", 32'(level0), 32'(lvl_before));

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 199) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
